// File: rtl/fft_iter_core.sv
// Iterative in-place radix-2 DIT FFT: one butterfly per clock over a single
// N-entry complex sample memory, loaded bit-reversed so results read out in natural order.
module fft_iter_core #(
  parameter int N_LOG2 = 3,
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write,
  input  logic [N_LOG2-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_real,
  input  logic signed [DATA_W-1:0] wr_imag,
  input  logic                     start,
  input  logic                     inverse,
  input  logic                     scale,
  input  logic [N_LOG2-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_real,
  output logic signed [DATA_W-1:0] rd_imag,
  output logic                     busy,
  output logic                     ready
);

  localparam int N     = 1 << N_LOG2;
  localparam int HALF  = N / 2;
  localparam int STG_W = $clog2(N_LOG2);
  localparam int BF_W  = N_LOG2 - 1;
  localparam int PW    = DATA_W + TW_W + 1;
  localparam int SW    = PW + 1;
  localparam int TW_SH = 32 - TW_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic signed [PW-1:0] RND  = PW'(64'd1 << (TW_W - 3));
  localparam logic signed [SW-1:0] SMAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [1:0]              r_state;
  logic [STG_W-1:0]        r_stage;
  logic [BF_W-1:0]         r_bfly;
  logic                    r_inverse;
  logic                    r_scale;
  logic signed [DATA_W-1:0] r_memRe [N];
  logic signed [DATA_W-1:0] r_memIm [N];
  logic signed [DATA_W-1:0] r_rdReal;
  logic signed [DATA_W-1:0] r_rdImag;

  logic [N_LOG2-1:0]        w_aIdx;
  logic [N_LOG2-1:0]        w_bIdx;
  logic [3:0]               w_twIdx;
  logic signed [TW_W-1:0]   w_wRe;
  logic signed [TW_W-1:0]   w_wIm;
  logic signed [PW-1:0]     w_pRe;
  logic signed [PW-1:0]     w_pIm;
  logic signed [PW-1:0]     w_pReR;
  logic signed [PW-1:0]     w_pImR;
  logic signed [SW-1:0]     w_sumARe;
  logic signed [SW-1:0]     w_sumAIm;
  logic signed [SW-1:0]     w_sumBRe;
  logic signed [SW-1:0]     w_sumBIm;
  logic signed [SW-1:0]     w_outARe;
  logic signed [SW-1:0]     w_outAIm;
  logic signed [SW-1:0]     w_outBRe;
  logic signed [SW-1:0]     w_outBIm;
  logic                     w_load;

  function automatic logic [N_LOG2-1:0] bitRev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
    return r;
  endfunction

  // cos(2*pi*i/32) in Q2.30 for i = 0..8; the rest of the half circle is folded onto these.
  function automatic logic signed [31:0] cosBase(input logic [3:0] i);
    case (i)
      4'd0:    return 32'sd1073741824;
      4'd1:    return 32'sd1053110176;
      4'd2:    return 32'sd992008094;
      4'd3:    return 32'sd892783698;
      4'd4:    return 32'sd759250125;
      4'd5:    return 32'sd596538995;
      4'd6:    return 32'sd410903207;
      4'd7:    return 32'sd209476638;
      default: return 32'sd0;
    endcase
  endfunction

  function automatic logic signed [31:0] cosM(input logic [3:0] m);
    if (m <= 4'd8) return cosBase(m);
    return -cosBase(4'(5'd16 - {1'b0, m}));
  endfunction

  function automatic logic signed [31:0] sinM(input logic [3:0] m);
    if (m <= 4'd8) return cosBase(4'd8 - m);
    return cosBase(m - 4'd8);
  endfunction

  function automatic logic signed [TW_W-1:0] toTw(input logic signed [31:0] v);
    logic signed [32:0] t;
    if (TW_SH == 0) return TW_W'(v);
    t = {v[31], v} + (33'sd1 <<< (TW_SH - 1));
    return TW_W'(t >>> TW_SH);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SMAX) return SMAX[DATA_W-1:0];
    if (v < SMIN) return SMIN[DATA_W-1:0];
    return v[DATA_W-1:0];
  endfunction

  // Butterfly addressing: bfly = {group, pair}; pair selects the twiddle (scaled to the 32-point table).
  always_comb begin
    int s;
    int j;
    int pair;
    s       = int'(r_stage);
    j       = int'(r_bfly);
    pair    = j & ((1 << s) - 1);
    w_aIdx  = N_LOG2'(((j >> s) << (s + 1)) | pair);
    w_bIdx  = w_aIdx | N_LOG2'(1 << s);
    w_twIdx = 4'(pair << (4 - s));
  end

  always_comb begin
    logic signed [TW_W-1:0] sinV;
    sinV  = toTw(sinM(w_twIdx));
    w_wRe = toTw(cosM(w_twIdx));
    w_wIm = r_inverse ? sinV : -sinV;
    w_pRe = PW'(r_memRe[w_bIdx]) * PW'(w_wRe) - PW'(r_memIm[w_bIdx]) * PW'(w_wIm);
    w_pIm = PW'(r_memRe[w_bIdx]) * PW'(w_wIm) + PW'(r_memIm[w_bIdx]) * PW'(w_wRe);
    w_pReR = (w_pRe + RND) >>> (TW_W - 2);
    w_pImR = (w_pIm + RND) >>> (TW_W - 2);
    w_sumARe = SW'(r_memRe[w_aIdx]) + SW'(w_pReR);
    w_sumAIm = SW'(r_memIm[w_aIdx]) + SW'(w_pImR);
    w_sumBRe = SW'(r_memRe[w_aIdx]) - SW'(w_pReR);
    w_sumBIm = SW'(r_memIm[w_aIdx]) - SW'(w_pImR);
    w_outARe = r_scale ? (w_sumARe >>> 1) : w_sumARe;
    w_outAIm = r_scale ? (w_sumAIm >>> 1) : w_sumAIm;
    w_outBRe = r_scale ? (w_sumBRe >>> 1) : w_sumBRe;
    w_outBIm = r_scale ? (w_sumBIm >>> 1) : w_sumBIm;
  end

  assign w_load = write && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_stage   <= '0;
      r_bfly    <= '0;
      r_inverse <= 1'b0;
      r_scale   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !write) begin
            r_state   <= COMPUTE;
            r_inverse <= inverse;
            r_scale   <= scale;
            r_stage   <= '0;
            r_bfly    <= '0;
          end
        end
        COMPUTE: begin
          if (r_bfly == BF_W'(HALF - 1)) begin
            r_bfly <= '0;
            if (r_stage == STG_W'(N_LOG2 - 1)) begin
              r_stage <= '0;
              r_state <= DONE;
            end else begin
              r_stage <= r_stage + STG_W'(1);
            end
          end else begin
            r_bfly <= r_bfly + BF_W'(1);
          end
        end
        DONE: begin
          if (write) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sample memory survives reset; loads and butterflies never overlap because they live in different states.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_load) begin
        r_memRe[bitRev(wr_addr)] <= wr_real;
        r_memIm[bitRev(wr_addr)] <= wr_imag;
      end else if (r_state == COMPUTE) begin
        r_memRe[w_aIdx] <= sat(w_outARe);
        r_memIm[w_aIdx] <= sat(w_outAIm);
        r_memRe[w_bIdx] <= sat(w_outBRe);
        r_memIm[w_bIdx] <= sat(w_outBIm);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdReal <= '0;
      r_rdImag <= '0;
    end else begin
      r_rdReal <= r_memRe[rd_addr];
      r_rdImag <= r_memIm[rd_addr];
    end
  end

  assign rd_real = r_rdReal;
  assign rd_imag = r_rdImag;
  assign busy    = (r_state == COMPUTE);
  assign ready   = (r_state == DONE);

endmodule

// File: tb/tb_fft_iter_core.sv
// Bench for fft_iter_core: an 8-point and a 32-point instance share stimulus,
// results are checked against a floating-point DFT model plus literal spot values.
module tb_fft_iter_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, write, start, inverse, scale, sel5;
  logic [4:0] wrAddr, rdAddr;
  logic signed [15:0] wrRe, wrIm;
  logic signed [15:0] rdRe3, rdIm3, rdRe5, rdIm5, rdRe, rdIm;
  logic busy3, ready3, busy5, ready5, busy, ready;

  fft_iter_core #(.N_LOG2(3), .DATA_W(16), .TW_W(16)) dut3 (
    .clk(clk), .rst(rst), .write(write & ~sel5), .wr_addr(wrAddr[2:0]),
    .wr_real(wrRe), .wr_imag(wrIm), .start(start & ~sel5), .inverse(inverse),
    .scale(scale), .rd_addr(rdAddr[2:0]), .rd_real(rdRe3), .rd_imag(rdIm3),
    .busy(busy3), .ready(ready3));

  fft_iter_core #(.N_LOG2(5), .DATA_W(16), .TW_W(16)) dut5 (
    .clk(clk), .rst(rst), .write(write & sel5), .wr_addr(wrAddr),
    .wr_real(wrRe), .wr_imag(wrIm), .start(start & sel5), .inverse(inverse),
    .scale(scale), .rd_addr(rdAddr), .rd_real(rdRe5), .rd_imag(rdIm5),
    .busy(busy5), .ready(ready5));

  assign rdRe  = sel5 ? rdRe5  : rdRe3;
  assign rdIm  = sel5 ? rdIm5  : rdIm3;
  assign busy  = sel5 ? busy5  : busy3;
  assign ready = sel5 ? ready5 : ready3;

  int total = 0;
  int bad = 0;
  int xRe [32];
  int xIm [32];
  int expRe [32];
  int expIm [32];
  int origRe [8];
  int tol = 2;
  bit armed = 1'b0;
  bit armQ = 1'b0;
  logic [4:0] addrQ = '0;

  task automatic checkOutput(input string name, input int act, input int exp, input int tl);
    total++;
    if (act - exp > tl || exp - act > tl) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tl);
    end
  endtask

  function automatic int clampRound(input real v);
    int r;
    r = $rtoi($floor(v + 0.5));
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Reference: direct DFT (or 1/N inverse DFT) of the loaded samples, clamped to the output range.
  task automatic computeModel(input int n, input bit inv, input bit scl);
    real ang, sr, si;
    for (int k = 0; k < n; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int m = 0; m < n; m++) begin
        ang = 2.0 * 3.14159265358979 * k * m / n;
        if (!inv) ang = -ang;
        sr += xRe[m] * $cos(ang) - xIm[m] * $sin(ang);
        si += xRe[m] * $sin(ang) + xIm[m] * $cos(ang);
      end
      if (scl) begin
        sr = sr / n;
        si = si / n;
      end
      expRe[k] = clampRound(sr);
      expIm[k] = clampRound(si);
    end
  endtask

  always @(posedge clk) begin
    addrQ <= rdAddr;
    armQ  <= armed;
  end

  always @(negedge clk) begin
    if (armed && armQ) begin
      if (!ready) checkOutput("ready_hold", 32'(ready), 1, 0);
      else begin
        checkOutput($sformatf("bin%0d_re", addrQ), int'(rdRe), expRe[addrQ], tol);
        checkOutput($sformatf("bin%0d_im", addrQ), int'(rdIm), expIm[addrQ], tol);
      end
    end
  end

  task automatic applyStimulus(input int n, input bit chkDrop);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 1 && chkDrop) checkOutput("ready_drop_on_write", 32'(ready), 0, 0);
      write = 1'b1; wrAddr = 5'(i); wrRe = 16'(xRe[i]); wrIm = 16'(xIm[i]);
    end
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic runTransform(input int n, input bit inv, input bit scl, input int expCyc, input bit noise);
    int cycles;
    @(posedge clk); #1;
    start = 1'b1; inverse = inv; scale = scl;
    @(posedge clk); #1;
    start = 1'b0; inverse = ~inv; scale = ~scl;
    checkOutput("busy_after_start", 32'(busy), 1, 0);
    cycles = 0;
    while (!ready && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if (noise && cycles == 2) start = 1'b1;
      if (noise && cycles == 3) begin
        start = 1'b0; write = 1'b1; wrAddr = 5'd0; wrRe = 16'sd30000; wrIm = -16'sd3000;
      end
      if (noise && cycles == 4) write = 1'b0;
    end
    inverse = 1'b0; scale = 1'b0;
    checkOutput($sformatf("latency_n%0d", n), cycles, expCyc, 0);
    checkOutput("busy_when_done", 32'(busy), 0, 0);
  endtask

  task automatic sweep(input int n);
    @(posedge clk); #1;
    armed = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rdAddr = 5'(i);
    end
    repeat (2) @(posedge clk);
    #1 armed = 1'b0;
  endtask

  task automatic readBin(input int a, output int re, output int im);
    @(posedge clk); #1;
    rdAddr = 5'(a);
    @(posedge clk); #1;
    re = int'(rdRe);
    im = int'(rdIm);
  endtask

  task automatic loadRamp();
    for (int i = 0; i < 8; i++) begin
      xRe[i] = 256 * i;
      xIm[i] = 0;
    end
  endtask

  initial begin
    int re, im;
    rst = 1'b0; write = 1'b0; start = 1'b0; inverse = 1'b0; scale = 1'b0; sel5 = 1'b0;
    wrAddr = '0; rdAddr = '0; wrRe = '0; wrIm = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy3), 0, 0);
    checkOutput("rst_ready", 32'(ready3), 0, 0);
    checkOutput("rst_rd_real", int'(rdRe3), 0, 0);
    checkOutput("rst_rd_imag", int'(rdIm3), 0, 0);
    checkOutput("rst_busy_n32", 32'(busy5), 0, 0);
    checkOutput("rst_ready_n32", 32'(ready5), 0, 0);
    rst = 1'b1;

    // Ramp, forward, unscaled
    loadRamp();
    applyStimulus(8, 1'b0);
    runTransform(8, 1'b0, 1'b0, 12, 1'b0);
    computeModel(8, 1'b0, 1'b0);
    readBin(0, re, im); checkOutput("ramp_X0_re", re, 7168, 0);  checkOutput("ramp_X0_im", im, 0, 0);
    readBin(2, re, im); checkOutput("ramp_X2_re", re, -1024, 0); checkOutput("ramp_X2_im", im, 1024, 0);
    readBin(4, re, im); checkOutput("ramp_X4_re", re, -1024, 0); checkOutput("ramp_X4_im", im, 0, 0);
    readBin(1, re, im); checkOutput("ramp_X1_re", re, -1024, 1); checkOutput("ramp_X1_im", im, 2472, 1);
    readBin(7, re, im); checkOutput("ramp_X7_re", re, -1024, 1); checkOutput("ramp_X7_im", im, -2472, 1);
    sweep(8);

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("start_in_done_busy", 32'(busy), 0, 0);
    checkOutput("start_in_done_ready", 32'(ready), 1, 0);

    // Ramp, forward, scaled by 1/N
    applyStimulus(8, 1'b1);
    runTransform(8, 1'b0, 1'b1, 12, 1'b0);
    computeModel(8, 1'b0, 1'b1);
    readBin(0, re, im); checkOutput("scaled_X0_re", re, 896, 1);
    readBin(4, re, im); checkOutput("scaled_X4_re", re, -128, 1);
    readBin(2, re, im); checkOutput("scaled_X2_re", re, -128, 1); checkOutput("scaled_X2_im", im, 128, 1);
    sweep(8);

    // Forward then inverse on the reloaded spectrum recovers the ramp
    applyStimulus(8, 1'b0);
    runTransform(8, 1'b0, 1'b0, 12, 1'b0);
    computeModel(8, 1'b0, 1'b0);
    sweep(8);
    for (int i = 0; i < 8; i++) begin
      origRe[i] = xRe[i];
      xRe[i] = expRe[i];
      xIm[i] = expIm[i];
    end
    applyStimulus(8, 1'b0);
    runTransform(8, 1'b1, 1'b1, 12, 1'b0);
    computeModel(8, 1'b1, 1'b1);
    sweep(8);
    for (int i = 0; i < 8; i++) begin
      readBin(i, re, im);
      checkOutput($sformatf("roundtrip_x%0d_re", i), re, origRe[i], 2);
      checkOutput($sformatf("roundtrip_x%0d_im", i), im, 0, 2);
    end

    // Full-scale DC saturates instead of wrapping
    for (int i = 0; i < 8; i++) begin
      xRe[i] = 32767;
      xIm[i] = 0;
    end
    applyStimulus(8, 1'b0);
    runTransform(8, 1'b0, 1'b0, 12, 1'b0);
    computeModel(8, 1'b0, 1'b0);
    readBin(0, re, im); checkOutput("sat_X0_re", re, 32767, 0);
    sweep(8);

    // Start and write while busy are ignored
    loadRamp();
    applyStimulus(8, 1'b0);
    runTransform(8, 1'b0, 1'b0, 12, 1'b1);
    computeModel(8, 1'b0, 1'b0);
    sweep(8);

    // Reset in the middle of a transform
    applyStimulus(8, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_busy", 32'(busy), 0, 0);
    checkOutput("midrst_ready", 32'(ready), 0, 0);
    checkOutput("midrst_rd_real", int'(rdRe), 0, 0);
    checkOutput("midrst_rd_imag", int'(rdIm), 0, 0);
    rst = 1'b1;

    @(posedge clk); #1;
    write = 1'b1; start = 1'b1; wrAddr = 5'd0; wrRe = '0; wrIm = '0;
    @(posedge clk); #1;
    write = 1'b0; start = 1'b0;
    checkOutput("start_with_write_busy", 32'(busy), 0, 0);

    // 32-point impulse
    sel5 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      xRe[i] = (i == 0) ? 1000 : 0;
      xIm[i] = 0;
    end
    applyStimulus(32, 1'b0);
    runTransform(32, 1'b0, 1'b0, 80, 1'b0);
    computeModel(32, 1'b0, 1'b0);
    readBin(17, re, im); checkOutput("impulse_X17_re", re, 1000, 0); checkOutput("impulse_X17_im", im, 0, 0);
    tol = 0;
    sweep(32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
